fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have parameter MEM_BYTES, default 16: instruction-memory size in bytes; power of two, at least 8.
REQ-002 The block SHALL have parameter RESET_PC, default 0: the PC loaded on reset.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 Port clk, input, 1: clock; all state updates on rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port fetch_enable, input, 1: level; permits new fetches.
REQ-007 Port Inst_Address, output, 64: byte address driven to instruction memory (combinational read).
REQ-008 Port Instruction, input, 32: memory read data for Inst_Address, valid in the same cycle.
REQ-009 Port branch_taken, input, 1: single-cycle redirect request.
REQ-010 Port branch_target, input, 64: redirect byte address; sampled when branch_taken=1.
REQ-011 Port out_valid, output, 1: Fetched_Instruction/Fetched_PC valid.
REQ-012 Port out_ready, input, 1: consumer accepts; transfer occurs when out_valid and out_ready are both 1.
REQ-013 Port Fetched_Instruction, output, 32: registered instruction word.
REQ-014 Port Fetched_PC, output, 64: address the word was fetched from.
REQ-015 Port misalign_err, output, 1: sticky error flag.
REQ-016 Port fetch_count, output, 16: number of accepted transfers.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and STALL.
REQ-018 In IDLE with fetch_enable=1, the next state SHALL be RUN; otherwise the FSM SHALL stay in IDLE.
REQ-019 In RUN, Inst_Address SHALL equal PC and the output registers SHALL load {Instruction, PC} when out_valid=0 or out_ready=1.
- On that edge: out_valid<=1 and PC<=PC+4.
- Latency: one cycle from address to out_valid; throughput one word per cycle while out_ready=1.
REQ-020 In RUN with out_valid=1 and out_ready=0, the next state SHALL be STALL.
- PC, Fetched_Instruction and Fetched_PC SHALL hold.
REQ-021 In STALL with out_ready=1, the held word SHALL transfer on that edge and the next state SHALL be RUN.
- No new word is loaded on that edge; out_valid<=0.
REQ-022 When fetch_enable=0 in RUN, no new word SHALL be loaded.
- A pending valid word SHALL stay valid until it transfers.
- The FSM SHALL then return to IDLE.
REQ-023 PC arithmetic SHALL be modulo MEM_BYTES; PC+4 reaching MEM_BYTES SHALL wrap to 0.
- Inst_Address upper bits above log2(MEM_BYTES) SHALL be 0.
REQ-024 branch_taken=1 SHALL take priority over every other event in every state.
- PC<=branch_target mod MEM_BYTES, with bits [1:0] forced to 0.
- out_valid<=0; any held or in-flight word is discarded and not counted.
- From RUN/STALL the next state SHALL be RUN; from IDLE the FSM SHALL stay in IDLE with the new PC.
REQ-025 branch_taken=1 with branch_target[1:0]!=0 SHALL set misalign_err=1 until reset; the redirect still proceeds per REQ-024.
REQ-026 fetch_count SHALL increment by 1 per transfer and saturate at 16'hFFFF.
REQ-027 A transfer and a branch_taken in the same cycle SHALL count the transfer; the redirect then applies.

Reset
REQ-028 On reset assertion, asynchronously: state=IDLE, PC=RESET_PC, out_valid=0, Fetched_Instruction=0, Fetched_PC=0, misalign_err=0, fetch_count=0.
REQ-029 Reset mid-transfer SHALL discard the word with no count.
REQ-030 The first fetch after reset release SHALL be from RESET_PC.

Structure
REQ-031 The shared package SHALL hold the state enum (IDLE/RUN/STALL), INST_BYTES=4 and the default RESET_PC.
REQ-032 The only sub-module SHALL be fetch_pc_gen (next-PC mux: hold / +4 wrap / redirect align-and-mask); the FSM and output registers SHALL live in fetch_sequencer.

Verification
REQ-033 Reset, fetch_enable=1, out_ready=1 -> Fetched_PC sequence 0,4,8,12,0 on consecutive cycles, out_valid=1 from the 2nd cycle, fetch_count=5 after five transfers.
REQ-034 out_ready=0 for 3 cycles while Fetched_PC=4 -> outputs stable, Inst_Address=8 held, state STALL; ready=1 -> transfer of PC 4, next word from PC 8.
REQ-035 branch_taken=1, branch_target=0x1C while a word is stalled -> stalled word dropped, count unchanged, next Fetched_PC=0xC.
REQ-036 branch_target=0x6 -> misalign_err=1 and stays 1; next Fetched_PC=0x4.
REQ-037 Reset asserted between clock edges mid-stream -> out_valid=0, fetch_count=0 immediately; after release, first Fetched_PC=RESET_PC.
REQ-038 fetch_enable=0 with a held word -> word transfers once out_ready=1, then out_valid=0 and the FSM returns to IDLE.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM states,
// instruction size and the default reset PC.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } fetch_state_e;

  localparam int unsigned INST_BYTES       = 4;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'd0;

endpackage

// File: rtl/fetch_pc_gen.sv
// Next-PC selection: redirect (word-aligned, masked to memory size),
// advance by one instruction with wrap, or hold.
module fetch_pc_gen
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned AW = 4
) (
  input  logic [AW-1:0] pc_i,
  input  logic          advance_i,
  input  logic          redirect_i,
  input  logic [AW-1:0] target_i,
  output logic [AW-1:0] pc_next_o
);

  // Wrap is implicit: the sum is truncated to the memory address width.
  always_comb begin
    pc_next_o = pc_i;
    if (redirect_i) begin
      pc_next_o = {target_i[AW-1:2], 2'b00};
    end else if (advance_i) begin
      pc_next_o = pc_i + AW'(INST_BYTES);
    end else begin
      pc_next_o = pc_i;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks a small instruction memory and hands
// words to a consumer over a valid/ready handshake, with branch redirects.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 16,
  parameter logic [63:0] RESET_PC  = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_enable,
  output logic [63:0] Inst_Address,
  input  logic [31:0] Instruction,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Fetched_Instruction,
  output logic [63:0] Fetched_PC,
  output logic        misalign_err,
  output logic [15:0] fetch_count
);

  localparam int unsigned AW = $clog2(MEM_BYTES);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] fpc_q, fpc_d;
  logic [31:0]   instr_q, instr_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [15:0]   count_q, count_d;
  logic          advance_s;
  logic          xfer_s;
  logic          target_unused;

  assign target_unused = ^branch_target[63:AW];
  assign xfer_s        = valid_q & out_ready;

  fetch_pc_gen #(.AW(AW)) u_pc_gen (
    .pc_i       (pc_q),
    .advance_i  (advance_s),
    .redirect_i (branch_taken),
    .target_i   (branch_target[AW-1:0]),
    .pc_next_o  (pc_d)
  );

  // A transfer is counted even when a branch lands on the same edge.
  always_comb begin
    state_d   = state_q;
    fpc_d     = fpc_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    err_d     = err_q;
    advance_s = 1'b0;
    if (xfer_s && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end else begin
      count_d = count_q;
    end
    if (branch_taken) begin
      valid_d = 1'b0;
      state_d = (state_q == IDLE) ? IDLE : RUN;
      if (branch_target[1:0] != 2'b00) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d = fetch_enable ? RUN : IDLE;
        end
        RUN: begin
          if (valid_q && !out_ready) begin
            state_d = STALL;
          end else if (fetch_enable) begin
            instr_d   = Instruction;
            fpc_d     = pc_q;
            valid_d   = 1'b1;
            advance_s = 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
        STALL: begin
          if (out_ready) begin
            valid_d = 1'b0;
            state_d = RUN;
          end else begin
            state_d = STALL;
          end
        end
        default: begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, PC and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC[AW-1:0];
      fpc_q   <= '0;
      instr_q <= 32'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fpc_q   <= fpc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  assign Inst_Address        = {{(64-AW){1'b0}}, pc_q};
  assign Fetched_PC          = {{(64-AW){1'b0}}, fpc_q};
  assign Fetched_Instruction = instr_q;
  assign out_valid           = valid_q;
  assign misalign_err        = err_q;
  assign fetch_count         = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: expected transfers are queued as
// stimulus is applied and checked when the consumer accepts a word.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic        clk;
  logic        reset;
  logic        fetch_enable;
  logic [63:0] Inst_Address;
  logic [31:0] Instruction;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Fetched_Instruction;
  logic [63:0] Fetched_PC;
  logic        misalign_err;
  logic [15:0] fetch_count;

  int          n_cmp;
  int          n_err;
  logic [63:0] exp_q[$];
  logic [63:0] mon_pc;

  fetch_sequencer #(.MEM_BYTES(16), .RESET_PC(64'd0)) dut (
    .clk                 (clk),
    .reset               (reset),
    .fetch_enable        (fetch_enable),
    .Inst_Address        (Inst_Address),
    .Instruction         (Instruction),
    .branch_taken        (branch_taken),
    .branch_target       (branch_target),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .Fetched_Instruction (Fetched_Instruction),
    .Fetched_PC          (Fetched_PC),
    .misalign_err        (misalign_err),
    .fetch_count         (fetch_count)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] addr);
    return 32'hC0DE_0000 | {16'h0000, addr[15:0]};
  endfunction

  assign Instruction = mem_word(Inst_Address);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Consumer side: inputs only change shortly after a rising edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL xfer_unexpected: observed pc %0h expected no transfer", Fetched_PC);
      end else begin
        mon_pc = exp_q.pop_front();
        check("xfer_pc", Fetched_PC, mon_pc);
        check("xfer_instr", 64'(Fetched_Instruction), 64'(mem_word(mon_pc)));
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    fetch_enable = 1'b0;
    out_ready = 1'b0;
    branch_taken = 1'b0;
    branch_target = 64'd0;
    repeat (2) tick();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_fpc", Fetched_PC, 64'd0);
    check("rst_finstr", 64'(Fetched_Instruction), 64'd0);
    check("rst_count", 64'(fetch_count), 64'd0);
    check("rst_err", 64'(misalign_err), 64'd0);
    check("rst_addr", Inst_Address, 64'd0);

    reset = 1'b0;
    fetch_enable = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(64'h0); exp_q.push_back(64'h4); exp_q.push_back(64'h8);
    exp_q.push_back(64'hC); exp_q.push_back(64'h0); exp_q.push_back(64'h4);
    tick();
    check("first_valid", 64'(out_valid), 64'd0);
    check("first_state", 64'(dut.state_q), 64'(RUN));
    tick();
    check("seq_fpc0", Fetched_PC, 64'h0);
    check("seq_valid", 64'(out_valid), 64'd1);
    repeat (3) tick();
    check("seq_fpc12", Fetched_PC, 64'hC);
    tick();
    check("wrap_fpc", Fetched_PC, 64'h0);
    check("wrap_count", 64'(fetch_count), 64'd4);
    tick();
    check("five_count", 64'(fetch_count), 64'd5);
    check("five_fpc", Fetched_PC, 64'h4);

    out_ready = 1'b0;
    tick();
    check("stall_state", 64'(dut.state_q), 64'(STALL));
    check("stall_addr", Inst_Address, 64'h8);
    repeat (2) tick();
    check("stall_hold_fpc", Fetched_PC, 64'h4);
    check("stall_hold_instr", 64'(Fetched_Instruction), 64'(mem_word(64'h4)));
    check("stall_hold_valid", 64'(out_valid), 64'd1);
    check("stall_hold_addr", Inst_Address, 64'h8);
    check("stall_hold_count", 64'(fetch_count), 64'd5);
    out_ready = 1'b1;
    tick();
    check("unstall_valid", 64'(out_valid), 64'd0);
    check("unstall_count", 64'(fetch_count), 64'd6);
    check("unstall_state", 64'(dut.state_q), 64'(RUN));
    tick();
    check("after_stall_fpc", Fetched_PC, 64'h8);

    out_ready = 1'b0;
    tick();
    check("pre_branch_state", 64'(dut.state_q), 64'(STALL));
    branch_taken = 1'b1;
    branch_target = 64'h1C;
    tick();
    branch_taken = 1'b0;
    check("br_drop_valid", 64'(out_valid), 64'd0);
    check("br_drop_count", 64'(fetch_count), 64'd6);
    check("br_addr", Inst_Address, 64'hC);
    check("br_aligned_err", 64'(misalign_err), 64'd0);
    out_ready = 1'b1;
    exp_q.push_back(64'hC);
    tick();
    check("br_fpc", Fetched_PC, 64'hC);

    branch_taken = 1'b1;
    branch_target = 64'h6;
    tick();
    branch_taken = 1'b0;
    check("mis_err", 64'(misalign_err), 64'd1);
    check("mis_xfer_count", 64'(fetch_count), 64'd7);
    check("mis_valid", 64'(out_valid), 64'd0);
    check("mis_addr", Inst_Address, 64'h4);
    exp_q.push_back(64'h4);
    tick();
    check("mis_fpc", Fetched_PC, 64'h4);

    fetch_enable = 1'b0;
    out_ready = 1'b0;
    repeat (2) tick();
    check("fe0_hold_valid", 64'(out_valid), 64'd1);
    check("fe0_hold_fpc", Fetched_PC, 64'h4);
    out_ready = 1'b1;
    tick();
    check("fe0_xfer_valid", 64'(out_valid), 64'd0);
    check("fe0_xfer_count", 64'(fetch_count), 64'd8);
    tick();
    check("fe0_idle", 64'(dut.state_q), 64'(IDLE));
    check("err_sticky", 64'(misalign_err), 64'd1);

    fetch_enable = 1'b1;
    exp_q.push_back(64'h8);
    repeat (3) tick();
    check("mid_count", 64'(fetch_count), 64'd9);
    check("mid_fpc", Fetched_PC, 64'hC);
    reset = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_count", 64'(fetch_count), 64'd0);
    check("arst_err", 64'(misalign_err), 64'd0);
    tick();
    reset = 1'b0;
    exp_q.push_back(64'h0);
    repeat (2) tick();
    check("post_rst_fpc", Fetched_PC, 64'h0);
    check("post_rst_valid", 64'(out_valid), 64'd1);
    tick();
    out_ready = 1'b0;
    check("post_rst_count", 64'(fetch_count), 64'd1);
    tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
